sha2_sigma_pipe: RTL and testbench

- Parametrised, pipelined SHA-2 sigma unit. It generalises the fixed 32-bit Σ0 function to all four SHA-2 sigma functions (Σ0, Σ1, σ0, σ1), which are selected per transaction.
- Supports 32-bit (SHA-256) and 64-bit (SHA-512) words, multiple parallel lanes and 1 or 2 register stages.
- Uses a valid/ready handshake with a tag carried through the pipeline. It sits between the message-schedule/round datapaths and their operand buffers in the miner core.

---
 rtl/sha2_sigma_pipe.sv | 155 +++++++++++++++
 tb/tb_sha2_sigma_pipe.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha2_sigma_pipe.sv
// Pipelined SHA-2 sigma unit: Σ0/Σ1/σ0/σ1 over LANES words of 32 or 64 bits,
// with a valid/ready handshake and a sideband tag carried alongside the data.
module sha2_sigma_pipe #(
  parameter int WIDTH  = 32,
  parameter int LANES  = 1,
  parameter int STAGES = 1,
  parameter int TAG_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_mode,
  input  logic [TAG_W-1:0]       in_tag,
  input  logic [LANES*WIDTH-1:0] in_x,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TAG_W-1:0]       out_tag,
  output logic [LANES*WIDTH-1:0] out_y
);

  localparam bit W64 = (WIDTH == 64);

  localparam int BS0_A = W64 ? 28 : 2;
  localparam int BS0_B = W64 ? 34 : 13;
  localparam int BS0_C = W64 ? 39 : 22;
  localparam int BS1_A = W64 ? 14 : 6;
  localparam int BS1_B = W64 ? 18 : 11;
  localparam int BS1_C = W64 ? 41 : 25;
  localparam int SS0_A = W64 ? 1  : 7;
  localparam int SS0_B = W64 ? 8  : 18;
  localparam int SS0_C = W64 ? 7  : 3;
  localparam int SS1_A = W64 ? 19 : 17;
  localparam int SS1_B = W64 ? 61 : 19;
  localparam int SS1_C = W64 ? 6  : 10;

  typedef struct packed {
    logic [WIDTH-1:0] t0;
    logic [WIDTH-1:0] t1;
    logic [WIDTH-1:0] t2;
  } terms_t;

  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] v, input int n);
    return (v >> n) | (v << (WIDTH - n));
  endfunction

  // The small sigmas use a plain shift as their third term, not a rotate.
  function automatic terms_t sigma_terms(input logic [1:0] mode, input logic [WIDTH-1:0] v);
    terms_t t;
    case (mode)
      2'd0:    t = '{rotr(v, BS0_A), rotr(v, BS0_B), rotr(v, BS0_C)};
      2'd1:    t = '{rotr(v, BS1_A), rotr(v, BS1_B), rotr(v, BS1_C)};
      2'd2:    t = '{rotr(v, SS0_A), rotr(v, SS0_B), v >> SS0_C};
      default: t = '{rotr(v, SS1_A), rotr(v, SS1_B), v >> SS1_C};
    endcase
    return t;
  endfunction

  function automatic logic [LANES*WIDTH-1:0] xor_terms(input terms_t [LANES-1:0] t);
    logic [LANES*WIDTH-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      r[l*WIDTH +: WIDTH] = t[l].t0 ^ t[l].t1 ^ t[l].t2;
    end
    return r;
  endfunction

  terms_t [LANES-1:0] in_terms;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      in_terms[l] = sigma_terms(in_mode, in_x[l*WIDTH +: WIDTH]);
    end
  end

  logic                   out_valid_q;
  logic [TAG_W-1:0]       out_tag_q;
  logic [LANES*WIDTH-1:0] out_y_q;

  assign out_valid = out_valid_q;
  assign out_tag   = out_tag_q;
  assign out_y     = out_y_q;

  if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
    $error("sha2_sigma_pipe: WIDTH must be 32 or 64");
  end

  if (STAGES == 1) begin : g_one
    logic [LANES*WIDTH-1:0] y_d;

    assign y_d      = xor_terms(in_terms);
    assign in_ready = !out_valid_q || out_ready;

    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_valid_q <= 1'b0;
        out_tag_q   <= '0;
        out_y_q     <= '0;
      end else if (in_ready) begin
        out_valid_q <= in_valid;
        if (in_valid) begin
          out_tag_q <= in_tag;
          out_y_q   <= y_d;
        end
      end
    end
  end else if (STAGES == 2) begin : g_two
    logic                   s1_valid_q;
    logic [TAG_W-1:0]       s1_tag_q;
    terms_t [LANES-1:0]     s1_terms_q;
    logic                   s1_adv;
    logic                   s2_adv;
    logic [LANES*WIDTH-1:0] y_d;

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign y_d      = xor_terms(s1_terms_q);

    // NOTE: data registers are reset too, so an empty stage never carries X
    // into downstream logic; the extra reset fan-out is cheap at this size.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_valid_q <= 1'b0;
        s1_tag_q   <= '0;
        s1_terms_q <= '0;
      end else if (s1_adv) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_tag_q   <= in_tag;
          s1_terms_q <= in_terms;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_valid_q <= 1'b0;
        out_tag_q   <= '0;
        out_y_q     <= '0;
      end else if (s2_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_tag_q <= s1_tag_q;
          out_y_q   <= y_d;
        end
      end
    end
  end else begin : g_bad_stages
    $error("sha2_sigma_pipe: STAGES must be 1 or 2");
  end

endmodule

// File: tb/tb_sha2_sigma_pipe.sv
// Scoreboard bench for sha2_sigma_pipe: three instances (32b/1 stage,
// 64b/2 stages, 4x32b/2 stages) driven with directed vectors.
module tb_sha2_sigma_pipe;

  typedef struct {
    logic [127:0] y;
    logic [7:0]   tag;
    int           cyc;
    bit           lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       iv   [3];
  logic       ordy [3];
  logic [1:0] md   [3];
  logic [7:0] tg   [3];
  logic [31:0]  x_a;
  logic [63:0]  x_b;
  logic [127:0] x_c;

  logic rdy_a, rdy_b, rdy_c, ov_a, ov_b, ov_c;
  logic [7:0]   tag_a, tag_b, tag_c;
  logic [31:0]  oy_a;
  logic [63:0]  oy_b;
  logic [127:0] oy_c;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  exp_t sb [3][$];

  sha2_sigma_pipe #(.WIDTH(32), .LANES(1), .STAGES(1), .TAG_W(8)) u_a (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rdy_a), .in_mode(md[0]),
    .in_tag(tg[0]), .in_x(x_a), .out_valid(ov_a), .out_ready(ordy[0]),
    .out_tag(tag_a), .out_y(oy_a));

  sha2_sigma_pipe #(.WIDTH(64), .LANES(1), .STAGES(2), .TAG_W(8)) u_b (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rdy_b), .in_mode(md[1]),
    .in_tag(tg[1]), .in_x(x_b), .out_valid(ov_b), .out_ready(ordy[1]),
    .out_tag(tag_b), .out_y(oy_b));

  sha2_sigma_pipe #(.WIDTH(32), .LANES(4), .STAGES(2), .TAG_W(8)) u_c (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(rdy_c), .in_mode(md[2]),
    .in_tag(tg[2]), .in_x(x_c), .out_valid(ov_c), .out_ready(ordy[2]),
    .out_tag(tag_c), .out_y(oy_c));

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic get_ov(input int d);
    case (d) 0: return ov_a; 1: return ov_b; default: return ov_c; endcase
  endfunction
  function automatic logic get_rdy(input int d);
    case (d) 0: return rdy_a; 1: return rdy_b; default: return rdy_c; endcase
  endfunction
  function automatic logic [7:0] get_tag(input int d);
    case (d) 0: return tag_a; 1: return tag_b; default: return tag_c; endcase
  endfunction
  function automatic logic [127:0] get_y(input int d);
    case (d) 0: return 128'(oy_a); 1: return 128'(oy_b); default: return oy_c; endcase
  endfunction
  function automatic int get_stg(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  // Reference: rotate taken as a window of the doubled word.
  function automatic logic [31:0] ref32(input logic [1:0] m, input logic [31:0] x);
    logic [63:0] xx;
    xx = {x, x};
    case (m)
      2'd0:    return xx[2 +: 32] ^ xx[13 +: 32] ^ xx[22 +: 32];
      2'd1:    return xx[6 +: 32] ^ xx[11 +: 32] ^ xx[25 +: 32];
      2'd2:    return xx[7 +: 32] ^ xx[18 +: 32] ^ (x >> 3);
      default: return xx[17 +: 32] ^ xx[19 +: 32] ^ (x >> 10);
    endcase
  endfunction

  function automatic logic [127:0] ref4(input logic [1:0] m, input logic [127:0] x);
    logic [127:0] r;
    for (int l = 0; l < 4; l++) r[l*32 +: 32] = ref32(m, x[l*32 +: 32]);
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input int d, input logic v, input logic [1:0] m,
                        input logic [7:0] t, input logic [127:0] x);
    iv[d] = v;
    md[d] = m;
    tg[d] = t;
    case (d)
      0:       x_a = x[31:0];
      1:       x_b = x[63:0];
      default: x_c = x;
    endcase
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int d, input logic [1:0] m, input logic [7:0] t,
                      input logic [127:0] x, input logic [127:0] ey,
                      input bit lat, input bit push, input bit want_rdy);
    int   n;
    bit   ok;
    exp_t e;
    set_in(d, 1'b1, m, t, x);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 300) begin
      @(negedge clk);
      if (get_rdy(d)) ok = 1'b1;
      else n++;
    end
    if (want_rdy) check($sformatf("in_ready_wait d%0d tag%0h", d, t), 128'(n), 128'(0));
    if (!ok) begin
      n_checks++;
      n_err++;
      $display("FAIL accept_timeout d%0d tag%0h: in_ready never rose", d, t);
    end else if (push) begin
      e.y   = ey;
      e.tag = t;
      e.cyc = cyc;
      e.lat = lat;
      sb[d].push_back(e);
    end
    @(posedge clk);
    #1;
    set_in(d, 1'b0, ~m, 8'hEE, ~x);
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while (sb[d].size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check($sformatf("drain_left d%0d", d), 128'(sb[d].size()), 128'(0));
    #1;
  endtask

  // Monitor: a transfer is due on the next edge whenever valid && ready here.
  logic         prev_stall [3];
  logic [127:0] prev_y     [3];
  logic [7:0]   prev_tag   [3];

  always @(negedge clk) begin
    logic [127:0] y;
    exp_t         e;
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        prev_stall[d] <= 1'b0;
        continue;
      end
      y = get_y(d);
      if (prev_stall[d]) begin
        check($sformatf("hold_valid d%0d", d), 128'(get_ov(d)), 128'(1));
        check($sformatf("hold_y d%0d", d), y, prev_y[d]);
        check($sformatf("hold_tag d%0d", d), 128'(get_tag(d)), 128'(prev_tag[d]));
      end
      if (get_ov(d) && ordy[d]) begin
        if (sb[d].size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_output d%0d: tag %h with empty scoreboard", d, get_tag(d));
        end else begin
          e = sb[d].pop_front();
          check($sformatf("out_tag d%0d", d), 128'(get_tag(d)), 128'(e.tag));
          check($sformatf("out_y d%0d tag%0h", d, e.tag), y, e.y);
          if (e.lat)
            check($sformatf("latency d%0d tag%0h", d, e.tag), 128'(cyc - e.cyc), 128'(get_stg(d)));
        end
      end
      prev_stall[d] <= get_ov(d) && !ordy[d];
      prev_y[d]     <= y;
      prev_tag[d]   <= get_tag(d);
    end
  end

  initial begin
    logic [127:0] x;
    logic [1:0]   m;

    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      set_in(d, 1'b0, 2'd0, 8'h00, 128'h0);
      ordy[d] = 1'b1;
    end
    #12;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_out_valid d%0d", d), 128'(get_ov(d)), 128'(0));
      check($sformatf("reset_out_y d%0d", d), get_y(d), 128'h0);
      check($sformatf("reset_out_tag d%0d", d), 128'(get_tag(d)), 128'(0));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++)
      check($sformatf("post_reset_in_ready d%0d", d), 128'(get_rdy(d)), 128'(1));
    @(posedge clk);
    #1;

    // 32-bit, 1 stage: all four functions, then SHR zero-fill on the MSB.
    send(0, 2'd0, 8'h10, 128'h1,        128'h40080400, 1, 1, 1);
    send(0, 2'd1, 8'h11, 128'h1,        128'h04200080, 1, 1, 1);
    send(0, 2'd2, 8'h12, 128'h1,        128'h02004000, 1, 1, 1);
    send(0, 2'd3, 8'h13, 128'h1,        128'h0000A000, 1, 1, 1);
    send(0, 2'd2, 8'h14, 128'h80000000, 128'h11002000, 1, 1, 1);
    send(0, 2'd3, 8'h15, 128'h80000000, 128'h00205000, 1, 1, 1);
    drain(0);

    // 64-bit, 2 stages.
    send(1, 2'd0, 8'h20, 128'h1,                 128'h0000001042000000, 1, 1, 1);
    send(1, 2'd1, 8'h21, 128'h1,                 128'h0004400000800000, 1, 1, 1);
    send(1, 2'd2, 8'h22, 128'h1,                 128'h8100000000000000, 1, 1, 1);
    send(1, 2'd3, 8'h23, 128'h1,                 128'h0000200000000008, 1, 1, 1);
    send(1, 2'd2, 8'h24, 128'h8000000000000000, 128'h4180000000000000, 1, 1, 1);
    send(1, 2'd3, 8'h25, 128'h8000000000000000, 128'h0200100000000004, 1, 1, 1);
    drain(1);

    // 4 lanes, 2 stages: 16 back-to-back transactions, mixed modes.
    for (int i = 0; i < 16; i++) begin
      for (int l = 0; l < 4; l++) x[l*32 +: 32] = 32'h9E3779B9 * 32'(i*4 + l + 1);
      m = 2'((i + i/4) % 4);
      send(2, m, 8'(i), x, ref4(m, x), 1, 1, 1);
    end
    drain(2);

    // Backpressure: fill, stall 5 cycles, then random out_ready.
    ordy[2] = 1'b0;
    x = 128'h0123456789ABCDEF_FEDCBA9876543210;
    send(2, 2'd0, 8'h40, x, ref4(2'd0, x), 0, 1, 1);
    send(2, 2'd3, 8'h41, ~x, ref4(2'd3, ~x), 0, 1, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_in_ready_full", 128'(get_rdy(2)), 128'(0));
    end
    @(posedge clk);
    #1;
    fork
      begin
        repeat (40) begin
          ordy[2] = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
        ordy[2] = 1'b1;
      end
      begin
        for (int i = 0; i < 8; i++) begin
          for (int l = 0; l < 4; l++) x[l*32 +: 32] = 32'h7F4A7C15 * 32'(i*4 + l + 3);
          m = 2'(i % 4);
          send(2, m, 8'(8'h42 + i), x, ref4(m, x), 0, 1, 0);
        end
      end
    join
    ordy[2] = 1'b1;
    drain(2);

    // Reset with two transactions in flight.
    ordy[2] = 1'b0;
    send(2, 2'd1, 8'h60, 128'h5, 128'h0, 0, 0, 1);
    send(2, 2'd2, 8'h61, 128'h6, 128'h0, 0, 0, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++)
      check($sformatf("rst_async_out_valid d%0d", d), 128'(get_ov(d)), 128'(0));
    @(negedge clk);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    ordy[2] = 1'b1;
    #1;
    check("rst_release_in_ready", 128'(get_rdy(2)), 128'(1));
    check("rst_release_out_valid", 128'(get_ov(2)), 128'(0));
    @(posedge clk);
    #1;
    x = {32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h12345678};
    send(2, 2'd2, 8'h70, x, ref4(2'd2, x), 1, 1, 1);
    drain(2);
    repeat (4) @(posedge clk);

    for (int d = 0; d < 3; d++)
      check($sformatf("final_scoreboard_empty d%0d", d), 128'(sb[d].size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
